// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment definitions for the scan decoder.
//   SEG_* constants are active-low segment patterns, bit order g..a (bit 6 = g).
//   seg_decode() maps a pattern to {recognised, digit}. Blank maps to {0, 4'h0}
//   and unknown patterns map to {0, 4'hF}.
// Build option: SEG_DECODE_HEX_EN adds the A,b,C,d,E,F glyphs as recognised.
//   With it, F decodes to 4'hF with recognised=1. Consumers must therefore use
//   the valid flag to detect errors, not the 4'hF value.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [3:0] digit_t;

   // Returns {recognised, digit}.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      r = {1'b0, 4'hF};
      case (seg)
         SEG_0:     r = {1'b1, 4'h0};
         SEG_1:     r = {1'b1, 4'h1};
         SEG_2:     r = {1'b1, 4'h2};
         SEG_3:     r = {1'b1, 4'h3};
         SEG_4:     r = {1'b1, 4'h4};
         SEG_5:     r = {1'b1, 4'h5};
         SEG_6:     r = {1'b1, 4'h6};
         SEG_7:     r = {1'b1, 4'h7};
         SEG_8:     r = {1'b1, 4'h8};
         SEG_9:     r = {1'b1, 4'h9};
         SEG_BLANK: r = {1'b0, 4'h0};
`ifdef SEG_DECODE_HEX_EN
         SEG_A:     r = {1'b1, 4'hA};
         SEG_B:     r = {1'b1, 4'hB};
         SEG_C:     r = {1'b1, 4'hC};
         SEG_D:     r = {1'b1, 4'hD};
         SEG_E:     r = {1'b1, 4'hE};
         SEG_F:     r = {1'b1, 4'hF};
`endif
         default:   r = {1'b0, 4'hF};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_dwell_filter.sv
// seg_dwell_filter: synchronises the AN/HEX bus and issues one capture strobe
// per stable dwell. This filters scanner ghosting and transition glitches.
// Ports:
//   clock, rst          system clock, async active-high reset
//   an_in, hex_in       raw active-low bus from the display scanner
//   capture             1-cycle strobe once the bus has held STABLE_CYCLES clocks
//   an_stable           synchronised anode value, valid when capture is high
//   hex_stable          synchronised segment value, valid when capture is high
module seg_dwell_filter #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [7:0] an_in,
   input  logic [7:0] hex_in,
   output logic       capture,
   output logic [7:0] an_stable,
   output logic [7:0] hex_stable
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [15:0]   s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d   = {an_in, hex_in};
      s2_d   = s1_q;
      prev_d = s2_q;
      cnt_d  = cnt_q;
      if (s2_q != prev_q)
         cnt_d = '0;
      else if (cnt_q != CW'(STABLE_CYCLES))
         cnt_d = cnt_q + CW'(1);
   end

   // Saturation at STABLE_CYCLES keeps this to one strobe per dwell.
   assign capture    = (s2_q == prev_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
   assign an_stable  = s2_q[15:8];
   assign hex_stable = s2_q[7:0];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         s1_q   <= 16'hFFFF;
         s2_q   <= 16'hFFFF;
         prev_q <= 16'hFFFF;
         cnt_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers 8 displayed digits from a multiplexed,
// active-low 7-segment bus (AN/HEX).
// Ports:
//   clock, rst      system clock, async active-high reset
//   an_in           anode enables, active-low (bit i low = digit i lit)
//   hex_in          segments, active-low: [6:0] = g..a, [7] = dp
//   digits          digit i value at [4i+3:4i] (4'hF = unrecognised)
//   dots            decimal point lit, per digit
//   valid           recognised and not stale, per digit
//   blank           last capture had all segments off, per digit
//   frame_valid     pulse: every FRAME_MASK digit captured since the last pulse
//   multi_an_err    pulse: a stable dwell had two or more anodes low
// Build option: SEG_DECODE_HEX_EN (see seg_pkg) enables hex glyph decode.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int         STABLE_CYCLES = 16,
   parameter int         STALE_CYCLES  = 1000000,
   parameter logic [7:0] FRAME_MASK    = 8'hFF
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [7:0]  an_in,
   input  logic [7:0]  hex_in,
   output logic [31:0] digits,
   output logic [7:0]  dots,
   output logic [7:0]  valid,
   output logic [7:0]  blank,
   output logic        frame_valid,
   output logic        multi_an_err
);

   localparam int SW = $clog2(STALE_CYCLES + 1);

   logic       capture;
   logic [7:0] an_s, hex_s;

   seg_dwell_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_dwell (
      .clock      (clock),
      .rst        (rst),
      .an_in      (an_in),
      .hex_in     (hex_in),
      .capture    (capture),
      .an_stable  (an_s),
      .hex_stable (hex_s)
   );

   logic [7:0] an_low;
   logic       one_low, many_low, cap_one;
   logic [7:0] new_bit;
   logic [4:0] dec;

   assign an_low   = ~an_s;
   assign one_low  = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
   assign many_low = (an_low != 8'h00) && !one_low;
   assign cap_one  = capture && one_low;
   assign new_bit  = cap_one ? an_low : 8'h00;
   assign dec      = seg_decode(hex_s[6:0]);

   logic [31:0]         digits_q, digits_d;
   logic [7:0]          dots_q, dots_d, valid_q, valid_d, blank_q, blank_d;
   logic [7:0]          seen_q, seen_d;
   logic                frame_valid_q, frame_valid_d;
   logic                multi_an_err_q, multi_an_err_d;
   logic [7:0][SW-1:0]  stale_q, stale_d;

   always_comb begin
      digits_d       = digits_q;
      dots_d         = dots_q;
      valid_d        = valid_q;
      blank_d        = blank_q;
      seen_d         = seen_q;
      stale_d        = stale_q;
      frame_valid_d  = 1'b0;
      multi_an_err_d = capture && many_low;

      for (int i = 0; i < 8; i++) begin
         // Free-running saturating age. The expiry cycle drops only the flags.
         if (stale_q[i] != SW'(STALE_CYCLES))
            stale_d[i] = stale_q[i] + SW'(1);
         if (stale_q[i] == SW'(STALE_CYCLES - 1)) begin
            valid_d[i] = 1'b0;
            blank_d[i] = 1'b0;
         end
         // A capture overrides an expiry in the same cycle.
         if (new_bit[i]) begin
            digits_d[4*i +: 4] = dec[3:0];
            dots_d[i]          = ~hex_s[7];
            valid_d[i]         = dec[4];
            blank_d[i]         = (hex_s[6:0] == SEG_BLANK);
            stale_d[i]         = '0;
         end
      end

      // The completing capture clears seen instead of setting its own bit,
      // so the next frame starts empty.
      if (cap_one) begin
         if (((seen_q | new_bit) & FRAME_MASK) == FRAME_MASK) begin
            frame_valid_d = 1'b1;
            seen_d        = 8'h00;
         end else begin
            seen_d = seen_q | new_bit;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         digits_q       <= '0;
         dots_q         <= '0;
         valid_q        <= '0;
         blank_q        <= '0;
         seen_q         <= '0;
         stale_q        <= '0;
         frame_valid_q  <= 1'b0;
         multi_an_err_q <= 1'b0;
      end else begin
         digits_q       <= digits_d;
         dots_q         <= dots_d;
         valid_q        <= valid_d;
         blank_q        <= blank_d;
         seen_q         <= seen_d;
         stale_q        <= stale_d;
         frame_valid_q  <= frame_valid_d;
         multi_an_err_q <= multi_an_err_d;
      end
   end

   assign digits       = digits_q;
   assign dots         = dots_q;
   assign valid        = valid_q;
   assign blank        = blank_q;
   assign frame_valid  = frame_valid_q;
   assign multi_an_err = multi_an_err_q;

endmodule
